// File: rtl/mux_deser_pkg.sv
// ----------------------------------------------------------------------------
// mux_deser_pkg
// Shared constants, the FSM state type and a slot-mask helper for the 1:31
// demultiplexing deserializer. mux_deser_if, mux_deser_slot_bank and
// mux_deser all import this package.
// ----------------------------------------------------------------------------
package mux_deser_pkg;

    localparam int NUM_SLOTS = 31;
    localparam int DW        = 2;
    localparam int SELW      = 5;

    // Select code 31 has no slot behind it and is reported as an error.
    localparam logic [SELW-1:0] SEL_INVALID = 5'd31;

    localparam logic [NUM_SLOTS-1:0] SLOT_ALL_VALID = {NUM_SLOTS{1'b1}};

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Returns a one-hot mask for a slot index. Index 31 shifts the single set
    // bit out of the vector, so the invalid code yields an all-zero mask.
    function automatic logic [NUM_SLOTS-1:0] slotMask(input logic [SELW-1:0] idx);
        logic [NUM_SLOTS-1:0] one;
        one = NUM_SLOTS'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/mux_deser_if.sv
// ----------------------------------------------------------------------------
// mux_deser_if
// Groups the symbol handshake, the frame output and the frame acknowledge of
// the deserializer into one bundle.
//   master : upstream producer and downstream consumer (drives in_*, frame_ack)
//   slave  : the deserializer itself (drives in_ready, out_flat, slot_valid,
//            frame_valid, err_sel)
// ----------------------------------------------------------------------------
interface mux_deser_if;

    logic                                                    in_valid;
    logic                                                    in_ready;
    logic [mux_deser_pkg::DW-1:0]                            in_data;
    logic [mux_deser_pkg::SELW-1:0]                          in_sel;
    logic                                                    addr_mode;
    logic [mux_deser_pkg::NUM_SLOTS*mux_deser_pkg::DW-1:0]   out_flat;
    logic [mux_deser_pkg::NUM_SLOTS-1:0]                     slot_valid;
    logic                                                    frame_valid;
    logic                                                    frame_ack;
    logic                                                    err_sel;

    modport master (
        output in_valid, in_data, in_sel, addr_mode, frame_ack,
        input  in_ready, out_flat, slot_valid, frame_valid, err_sel
    );

    modport slave (
        input  in_valid, in_data, in_sel, addr_mode, frame_ack,
        output in_ready, out_flat, slot_valid, frame_valid, err_sel
    );

endinterface

// File: rtl/mux_deser_slot_bank.sv
// ----------------------------------------------------------------------------
// mux_deser_slot_bank
// The 31 two-bit slot registers plus the per-slot "written this frame" flags.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   wr_en_i       : write wr_data_i into slot wr_idx_i at the next edge
//   wr_idx_i      : target slot, 0..30 (the caller never enables a write to 31)
//   wr_data_i     : symbol to store
//   clr_valid_i   : clear every slot_valid flag; slot data is left untouched
//   out_flat_o    : slot i on bits [2i+1:2i]
//   slot_valid_o  : bit i set once slot i has been written this frame
// ----------------------------------------------------------------------------
module mux_deser_slot_bank
    import mux_deser_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [SELW-1:0]           wr_idx_i,
    input  logic [DW-1:0]             wr_data_i,
    input  logic                      clr_valid_i,
    output logic [NUM_SLOTS*DW-1:0]   out_flat_o,
    output logic [NUM_SLOTS-1:0]      slot_valid_o
);

    logic [NUM_SLOTS*DW-1:0] slots_q, slots_d;
    logic [NUM_SLOTS-1:0]    valid_q, valid_d;

    // Next-state for the bank. A clear starts a new frame but keeps the old
    // data visible until each slot is overwritten. Clear and write never
    // coincide because clears only happen while the FSM holds a frame.
    always_comb begin
        slots_d = slots_q;
        valid_d = valid_q;
        if (clr_valid_i) begin
            valid_d = '0;
        end
        if (wr_en_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_idx_i == SELW'(i)) begin
                    slots_d[i*DW +: DW] = wr_data_i;
                end
            end
            valid_d = valid_d | slotMask(wr_idx_i);
        end
    end

    // Slot storage and the valid flags, both cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            valid_q <= '0;
        end else begin
            slots_q <= slots_d;
            valid_q <= valid_d;
        end
    end

    assign out_flat_o   = slots_q;
    assign slot_valid_o = valid_q;

endmodule

// File: rtl/mux_deser.sv
// ----------------------------------------------------------------------------
// mux_deser
// Registered 1:31 demultiplexing deserializer. Each accepted 2-bit symbol is
// steered into a slot chosen either by in_sel (addressed mode) or by an
// internal wrapping pointer (auto mode). Once all 31 slots are fresh the
// frame is presented on frame_valid and held until frame_ack.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : mux_deser_if.slave - symbol handshake (in_valid/in_ready,
//              in_data, in_sel, addr_mode), frame output (out_flat,
//              slot_valid, frame_valid), frame_ack and the err_sel pulse
// ----------------------------------------------------------------------------
module mux_deser
    import mux_deser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mux_deser_if.slave  bus
);

    state_e              state_q;
    logic [SELW-1:0]     wr_ptr_q;
    logic                frame_valid_q;
    logic                err_sel_q;

    logic                accept;
    logic                selInvalid;
    logic                wrEn;
    logic [SELW-1:0]     wrIdx;
    logic                frameDone;
    logic                clearValid;
    logic [NUM_SLOTS-1:0] slotValid;

    // Ready is purely a state decode, forced low during reset so nothing is
    // taken while the block is being cleared.
    assign bus.in_ready = (state_q == FILL) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    // Select resolution. frameDone looks ahead at the valid vector as it will
    // be after this write, so the FSM enters HOLD on the very edge that fills
    // the last slot.
    always_comb begin
        wrIdx      = bus.addr_mode ? bus.in_sel : wr_ptr_q;
        selInvalid = bus.addr_mode && (bus.in_sel == SEL_INVALID);
        wrEn       = accept && !selInvalid;
        frameDone  = wrEn && ((slotValid | slotMask(wrIdx)) == SLOT_ALL_VALID);
        clearValid = (state_q == HOLD) && bus.frame_ack;
    end

    // Control FSM with registered frame_valid and err_sel. The pointer only
    // moves on accepted auto-mode beats and restarts at slot 0 for each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wr_ptr_q      <= '0;
            frame_valid_q <= 1'b0;
            err_sel_q     <= 1'b0;
        end else begin
            err_sel_q <= accept && selInvalid;
            case (state_q)
                FILL: begin
                    if (accept && !bus.addr_mode) begin
                        wr_ptr_q <= (wr_ptr_q == SELW'(NUM_SLOTS - 1)) ? '0 : wr_ptr_q + 1'b1;
                    end
                    if (frameDone) begin
                        state_q       <= HOLD;
                        frame_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.frame_ack) begin
                        state_q       <= FILL;
                        frame_valid_q <= 1'b0;
                        wr_ptr_q      <= '0;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    mux_deser_slot_bank u_bank (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wrEn),
        .wr_idx_i     (wrIdx),
        .wr_data_i    (bus.in_data),
        .clr_valid_i  (clearValid),
        .out_flat_o   (bus.out_flat),
        .slot_valid_o (slotValid)
    );

    assign bus.slot_valid  = slotValid;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_sel     = err_sel_q;

endmodule

// File: doc/mux_deser.md
Name: mux_deser

Overview:
- Inverse-direction companion to the 31:1 two-bit selector mux: a registered 1:31 demultiplexing deserializer.
- Accepts 2-bit symbols over a valid/ready handshake and steers each into one of 31 slot registers.
- Slot selection is either by an explicit 5-bit select (addressed mode) or by an internal auto-incrementing pointer (auto mode).
- When all 31 slots hold fresh data, the block presents a complete frame and holds it until acknowledged.

Parameters:
- NUM_SLOTS, 31, number of slot registers (fixed; select code 31 is the invalid code).
- DW, 2, symbol and slot width in bits.
- SELW, 5, select width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input symbol valid.
- in_ready  output  1  block can accept a symbol.
- in_data  input  DW  symbol to store.
- in_sel  input  SELW  target slot in addressed mode; values 0..30 are valid, 31 is invalid.
- addr_mode  input  1  1 = addressed mode using in_sel; 0 = auto mode using the internal pointer. Sampled per accepted beat.
- out_flat  output  NUM_SLOTS*DW  slot i appears on bits [2i+1:2i].
- slot_valid  output  NUM_SLOTS  bit i is set once slot i has been written in the current frame.
- frame_valid  output  1  all slots written; frame held stable.
- frame_ack  input  1  consumer has taken the frame.
- err_sel  output  1  one-cycle pulse on an accepted addressed beat with in_sel=31.

Behaviour:
- States:
  - FILL: in_ready=1.
  - HOLD: in_ready=0, frame_valid=1.
  - in_ready is a registered-state decode and is 0 while rst is high.
- Reset values: state=FILL, out_flat=0, slot_valid=0, frame_valid=0, err_sel=0, wr_ptr=0.
- Beat acceptance: a beat is accepted when in_valid & in_ready.
  - Slot data and the slot_valid bit update at the next rising edge, so the write is visible one cycle after acceptance.
- Auto mode:
  - Target slot = wr_ptr.
  - wr_ptr increments; after 30 it wraps to 0.
- Addressed mode:
  - Target slot = in_sel. wr_ptr is unchanged.
  - in_sel=31: no slot write and no slot_valid change; err_sel=1 for exactly one cycle.
- Rewriting a slot that is already valid overwrites its data; its slot_valid bit stays set. Mixed auto and addressed beats within one frame are legal.
- FILL -> HOLD: on the edge where the accepted write makes all 31 slot_valid bits set. frame_valid=1 from the following cycle.
- In HOLD:
  - in_valid is ignored; the upstream beat remains pending because in_ready=0.
  - out_flat is frozen.
- HOLD -> FILL: on frame_ack=1.
  - Next cycle: frame_valid=0, slot_valid=0, wr_ptr=0, in_ready=1.
  - out_flat keeps the old data until each slot is overwritten.
- frame_ack in FILL is ignored.
- Simultaneous rst with any other event: rst wins. A reset mid-frame discards all partial state and returns to the reset values.
- No combinational path from in_data or in_sel to any output.

Decomposition:
- Package mux_deser_pkg holds:
  - NUM_SLOTS, DW, SELW.
  - SEL_INVALID = 5'd31.
  - State enum {FILL, HOLD}.
  - SLOT_ALL_VALID = {NUM_SLOTS{1'b1}}.
- One natural sub-module, mux_deser_slot_bank:
  - Contains the 31 slot registers and the slot_valid vector.
  - Inputs: write enable, write index, data, clear-valid.
  - Output: out_flat and slot_valid.
- The top level holds the FSM, wr_ptr, select resolution and err_sel.

Test Plan:
- Reset: assert rst for 3 cycles with in_valid=1 -> out_flat=0, slot_valid=0, frame_valid=0, in_ready=0 during reset, in_ready=1 the cycle after release.
- Auto fill: addr_mode=0, 31 back-to-back beats with data=i%4 -> the cycle after the 31st beat, frame_valid=1, in_ready=0, slot i = i%4 (slot 30 = 2). A 32nd beat held valid is not accepted.
- Ack and refill: in HOLD, pulse frame_ack -> next cycle frame_valid=0, slot_valid=0, in_ready=1, out_flat unchanged. The pending beat data=3 lands in slot 0 and sets slot_valid=1 only at bit 0.
- Addressed plus error:
  - sel=5 data=3, then sel=5 data=1 -> slot 5 = 1, slot_valid = only bit 5 set.
  - sel=31 data=2 -> err_sel pulses for 1 cycle, no slot or valid change.
  - Writing the remaining 30 slots by address (order 30 down to 0) -> frame_valid=1.
- Mid-frame reset: 10 auto beats, then rst for 1 cycle -> all outputs return to reset values. The next auto beat targets slot 0.
- Mixed mode: 3 auto beats (slots 0-2), addressed beat sel=1 data=0, then auto beat -> slot 1 = 0, the auto beat lands in slot 3, slot_valid = 4'b1111 in the low bits.
